// File: rtl/mem_port_arbiter_if.sv
// Bundle between the dual-requester memory port arbiter and its environment.
// master = arbiter side, slave = cache controllers plus memory side.
interface mem_port_arbiter_if #(
  parameter int ADR_W  = 16,
  parameter int DATA_W = 8,
  parameter int BEATS  = 4
) ();
  localparam int BW = $clog2(BEATS);

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADR_W-1:0]  adr0;
  logic [ADR_W-1:0]  adr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic              err0;
  logic              err1;
  logic [BW-1:0]     beat;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              readyMem;
  logic              readMem;
  logic              writeMem;
  logic [ADR_W-1:0]  adrMM;
  logic [DATA_W-1:0] dataMMin;
  logic [DATA_W-1:0] dataMMout;

  modport master (
    input  req0, req1, we0, we1, adr0, adr1, wdata0, wdata1, readyMem, dataMMin,
    output gnt0, gnt1, done0, done1, err0, err1, beat, rdata, rvalid,
           readMem, writeMem, adrMM, dataMMout
  );

  modport slave (
    output req0, req1, we0, we1, adr0, adr1, wdata0, wdata1, readyMem, dataMMin,
    input  gnt0, gnt1, done0, done1, err0, err1, beat, rdata, rvalid,
           readMem, writeMem, adrMM, dataMMout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter giving two cache controllers block access to one memory port.
// Optional WAIT-state timeout enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADR_W  = 16,
  parameter int DATA_W = 8,
  parameter int BEATS  = 4
) (
  input logic                CLK,
  input logic                RST,
  mem_port_arbiter_if.master bus
);
  localparam int BW = $clog2(BEATS);
  localparam logic [BW-1:0]    LAST_BEAT = BW'(BEATS - 1);
  localparam logic [ADR_W-1:0] LOW_MASK  = ADR_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, XFER, DONE} state_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic [ADR_W-1:0]  base_q, base_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              done_q, done_d;
`ifdef ARB_TIMEOUT_EN
  logic              err_q, err_d;
  logic [7:0]        tmo_q, tmo_d;
`endif
  logic              readMem_c;
  logic              writeMem_c;
  logic [ADR_W-1:0]  adrMM_c;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b1;
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      base_q   <= '0;
      beat_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err_q    <= 1'b0;
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      base_q   <= base_d;
      beat_q   <= beat_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
`ifdef ARB_TIMEOUT_EN
      err_q    <= err_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  // ptr_q remembers the last requester served; a tie goes to the other one.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    we_d       = we_q;
    base_d     = base_q;
    beat_d     = beat_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    done_d     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    err_d      = 1'b0;
    tmo_d      = tmo_q;
`endif
    readMem_c  = 1'b0;
    writeMem_c = 1'b0;
    adrMM_c    = '0;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          sel_d   = (bus.req0 && bus.req1) ? ~ptr_q : bus.req1;
          we_d    = sel_d ? bus.we1 : bus.we0;
          base_d  = (sel_d ? bus.adr1 : bus.adr0) & ~LOW_MASK;
          beat_d  = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        adrMM_c = base_q;
        if (bus.readyMem) begin
          readMem_c  = !we_q;
          writeMem_c = we_q;
          state_d    = WAIT;
`ifdef ARB_TIMEOUT_EN
          tmo_d      = '0;
`endif
        end
      end
      WAIT: begin
        adrMM_c = base_q;
        if (bus.readyMem) begin
          beat_d  = '0;
          state_d = XFER;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_q == 8'hFF) begin
          err_d   = 1'b1;
          ptr_d   = sel_q;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      XFER: begin
        adrMM_c = base_q | ADR_W'(beat_q);
        if (!we_q) begin
          rdata_d  = bus.dataMMin;
          rvalid_d = 1'b1;
        end
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        ptr_d   = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt0      = (state_q != IDLE) && !sel_q;
  assign bus.gnt1      = (state_q != IDLE) && sel_q;
  assign bus.done0     = done_q && !sel_q;
  assign bus.done1     = done_q && sel_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.err0      = err_q && !sel_q;
  assign bus.err1      = err_q && sel_q;
`else
  assign bus.err0      = 1'b0;
  assign bus.err1      = 1'b0;
`endif
  assign bus.beat      = beat_q;
  assign bus.rdata     = rdata_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.readMem   = readMem_c;
  assign bus.writeMem  = writeMem_c;
  assign bus.adrMM     = adrMM_c;
  // Write data is steered straight from the owner so each beat needs no extra cycle.
  assign bus.dataMMout = (state_q == XFER && we_q) ? (sel_q ? bus.wdata1 : bus.wdata0) : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a read-data scoreboard queue.
// Define ARB_TIMEOUT_EN for both bench and RTL to exercise the WAIT timeout.
module tb_mem_port_arbiter;
  logic CLK;
  logic RST;
  int   total;
  int   bad;
  int   cyc;
  logic [7:0] rdQ[$];
  logic [7:0] wrQ[$];

  mem_port_arbiter_if #(.ADR_W(16), .DATA_W(8), .BEATS(4)) bus ();

  mem_port_arbiter #(.ADR_W(16), .DATA_W(8), .BEATS(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every cycle: ownership and strobe exclusivity, and rvalid against the scoreboard.
  task automatic tick();
    logic [7:0] exp;
    @(posedge CLK);
    #1;
    cyc++;
    checkOutput("gntExcl", 32'(bus.gnt0 & bus.gnt1), 0);
    checkOutput("strobeExcl", 32'(bus.readMem & bus.writeMem), 0);
    checkOutput("rvalidPending", 32'(bus.rvalid), 32'(rdQ.size() != 0));
    if (bus.rvalid && rdQ.size() != 0) begin
      exp = rdQ.pop_front();
      checkOutput("rdata", 32'(bus.rdata), 32'(exp));
    end
  endtask

  task automatic applyStimulus(input int who, input logic r, input logic w, input logic [15:0] a);
    if (who == 0) begin
      bus.req0 = r; bus.we0 = w; bus.adr0 = a;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.adr1 = a;
    end
  endtask

  function automatic logic gntOf(input int who);
    return (who == 0) ? bus.gnt0 : bus.gnt1;
  endfunction

  function automatic logic doneOf(input int who);
    return (who == 0) ? bus.done0 : bus.done1;
  endfunction

  task automatic doBlock(input int who, input logic we, input logic [15:0] adr,
                         input logic [31:0] pat, input int issueStall, input int waitStall);
    logic [15:0] base;
    logic [7:0]  b;
    int          t0;
    base = adr & 16'hFFFC;
    applyStimulus(who, 1'b1, we, adr);
    bus.readyMem = (issueStall == 0);
    tick();
    t0 = cyc;
    checkOutput("gnt", 32'(gntOf(who)), 1);
    checkOutput("gntOther", 32'(gntOf(1 - who)), 0);
    applyStimulus(who, 1'b0, ~we, 16'hFFFF);
    for (int i = 0; i < issueStall; i++) begin
      checkOutput("issueHold", 32'({bus.readMem, bus.writeMem}), 0);
      tick();
    end
    bus.readyMem = 1'b1;
    #1;
    checkOutput("strobe", 32'({bus.readMem, bus.writeMem}), we ? 32'h1 : 32'h2);
    checkOutput("issueAdr", 32'(bus.adrMM), 32'(base));
    tick();
    if (waitStall > 0) bus.readyMem = 1'b0;
    for (int i = 0; i < waitStall; i++) begin
      checkOutput("waitNoStrobe", 32'({bus.readMem, bus.writeMem}), 0);
      checkOutput("waitGnt", 32'(gntOf(who)), 1);
      tick();
    end
    bus.readyMem = 1'b1;
    checkOutput("waitNoStrobe", 32'({bus.readMem, bus.writeMem}), 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      b = pat[31-8*k -: 8];
      checkOutput("beat", 32'(bus.beat), k);
      checkOutput("xferAdr", 32'(bus.adrMM), 32'(base) + k);
      if (we) begin
        if (who == 0) bus.wdata0 = b; else bus.wdata1 = b;
        wrQ.push_back(b);
        #1;
        checkOutput("dataMMout", 32'(bus.dataMMout), 32'(wrQ.pop_front()));
      end else begin
        bus.dataMMin = b;
        rdQ.push_back(b);
      end
      tick();
    end
    checkOutput("doneEarly", 32'(doneOf(who)), 0);
    tick();
    checkOutput("done", 32'(doneOf(who)), 1);
    checkOutput("gntDrop", 32'(gntOf(who)), 0);
    checkOutput("latency", 32'(cyc - t0), 32'(7 + issueStall + waitStall));
    tick();
    checkOutput("donePulse", 32'(doneOf(who)), 0);
    checkOutput("rdQEmpty", 32'(rdQ.size()), 0);
  endtask

  initial begin
    int seen[$];
    logic p0, p1;
    int n;
    total = 0; bad = 0; cyc = 0;
    RST = 1'b0;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.adr0 = '0; bus.adr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.readyMem = 1'b1; bus.dataMMin = '0;
    #3;
    $display("[TB] reset state");
    checkOutput("rstGnt", 32'({bus.gnt0, bus.gnt1}), 0);
    checkOutput("rstDone", 32'({bus.done0, bus.done1, bus.err0, bus.err1}), 0);
    checkOutput("rstStrobe", 32'({bus.readMem, bus.writeMem, bus.rvalid}), 0);
    checkOutput("rstAdr", 32'(bus.adrMM), 0);
    checkOutput("rstData", 32'({bus.rdata, bus.dataMMout}), 0);
    checkOutput("rstBeat", 32'(bus.beat), 0);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    tick();

    $display("[TB] round-robin with both requesters held");
    applyStimulus(0, 1'b1, 1'b1, 16'h0400);
    applyStimulus(1, 1'b1, 1'b1, 16'h0800);
    p0 = 0; p1 = 0;
    for (int c = 0; c < 200 && seen.size() < 4; c++) begin
      tick();
      if (bus.gnt0 && !p0) seen.push_back(0);
      if (bus.gnt1 && !p1) seen.push_back(1);
      p0 = bus.gnt0; p1 = bus.gnt1;
    end
    applyStimulus(0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1, 1'b0, 1'b0, 16'h0000);
    checkOutput("altCount", 32'(seen.size()), 4);
    for (int k = 0; k < seen.size(); k++) checkOutput("altOrder", 32'(seen[k]), 32'(k % 2));
    n = 0;
    while (n < 30 && (bus.gnt0 || bus.gnt1)) begin tick(); n++; end
    checkOutput("altIdle", 32'({bus.gnt0, bus.gnt1}), 0);
    tick();

    $display("[TB] line fill from requester 0");
    doBlock(0, 1'b0, 16'h0093, 32'hAABBCCDD, 0, 0);
    $display("[TB] write-back from requester 1");
    doBlock(1, 1'b1, 16'h1234, 32'h11223344, 0, 0);
    $display("[TB] stalled ISSUE and WAIT");
    doBlock(0, 1'b0, 16'h4567, 32'h5A6B7C8D, 3, 5);

    $display("[TB] reset during beat 2");
    bus.readyMem = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 16'h2200);
    tick();
    checkOutput("rstTxnGnt", 32'(bus.gnt0), 1);
    applyStimulus(0, 1'b0, 1'b0, 16'h2200);
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      bus.dataMMin = 8'h60 + 8'(k);
      rdQ.push_back(8'h60 + 8'(k));
      tick();
    end
    checkOutput("rstPreBeat", 32'(bus.beat), 2);
    RST = 1'b0;
    #1;
    checkOutput("abortGnt", 32'({bus.gnt0, bus.gnt1}), 0);
    checkOutput("abortStrobe", 32'({bus.readMem, bus.writeMem, bus.rvalid}), 0);
    checkOutput("abortBeat", 32'(bus.beat), 0);
    checkOutput("abortAdr", 32'(bus.adrMM), 0);
    checkOutput("abortRdata", 32'(bus.rdata), 0);
    rdQ.delete();
    repeat (3) begin
      tick();
      checkOutput("abortNoDone", 32'(bus.done0), 0);
    end
    RST = 1'b1;
    doBlock(0, 1'b0, 16'h2203, 32'h01020304, 0, 0);

`ifdef ARB_TIMEOUT_EN
    $display("[TB] WAIT timeout");
    bus.readyMem = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 16'h3000);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 16'h3000);
    tick();
    bus.readyMem = 1'b0;
    n = 0; p0 = 0;
    while (n < 300 && !p0) begin
      tick();
      n++;
      if (bus.err0) p0 = 1;
    end
    checkOutput("tmoErr", 32'(p0), 1);
    checkOutput("tmoCycles", 32'(n), 256);
    checkOutput("tmoGnt", 32'(bus.gnt0), 0);
    tick();
    checkOutput("tmoErrPulse", 32'(bus.err0), 0);
    bus.readyMem = 1'b1;
`else
    $display("[TB] long WAIT without timeout");
    doBlock(0, 1'b0, 16'h3000, 32'hCAFEF00D, 0, 300);
    checkOutput("noErr", 32'({bus.err0, bus.err1}), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
